// File: rtl/param_multi_bank_memory.sv
// param_multi_bank_memory
//
// Dual-port memory with one read and one write per cycle. It is built from
// BANKS x SUBBANKS single-port arrays of DEPTH words each. A read always wins
// a sub-bank collision. A write that loses a collision is parked in a
// one-entry pending buffer and retired later, so writes are never dropped.
// While a write is pending, a read of exactly that address is forwarded from
// the buffer, so the pending write appears to be already complete.
//
// Address map: {bank, sub-bank, row}. The upper ADDR_W-ROW_W bits form the
// sub-bank ID.
//
// Ports:
//   clk          in   single clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   ren          in   read request
//   raddr        in   read address
//   dout         out  registered read data, 0 whenever rvalid=0
//   rvalid       out  dout valid (1-cycle read latency)
//   wen          in   write request, accepted only while wready=1
//   waddr        in   write address
//   din          in   write data
//   wready       out  write can be accepted (= no pending entry)
//   conflict_cnt out  saturating count of blocked-write cycles
module param_multi_bank_memory #(
  parameter int DATA_W   = 8,
  parameter int BANKS    = 4,
  parameter int SUBBANKS = 4,
  parameter int DEPTH    = 128,
  parameter int CNT_W    = 16,
  localparam int ADDR_W  = $clog2(BANKS) + $clog2(SUBBANKS) + $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  output logic              wready,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int ROW_W = $clog2(DEPTH);
  localparam int WORDS = BANKS * SUBBANKS * DEPTH;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // The address is already {bank, sub-bank, row}. Indexing one flat array
  // with it therefore keeps every sub-bank a separate block of DEPTH words.
  // The conflict logic guarantees that no sub-bank sees two accesses in one
  // cycle.
  logic [DATA_W-1:0] mem [WORDS];

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic              accept;
  logic              cand_valid;
  logic [ADDR_W-1:0] cand_addr;
  logic [DATA_W-1:0] cand_data;
  logic              conflict;
  logic              commit;
  logic              fwd;

  assign wready = !pend_valid;

  always_comb begin
    accept     = wen && !pend_valid;
    cand_valid = pend_valid || accept;
    cand_addr  = pend_valid ? pend_addr : waddr;
    cand_data  = pend_valid ? pend_data : din;
    conflict   = ren && cand_valid &&
                 (cand_addr[ADDR_W-1:ROW_W] == raddr[ADDR_W-1:ROW_W]);
    // Gated by rst_n so that a pending entry is discarded at reset rather
    // than slipping into the array on the reset edge.
    commit     = rst_n && cand_valid && !conflict;
    fwd        = pend_valid && (raddr == pend_addr);
  end

  // Array write stage: at most one commit per cycle, contents never reset.
  always_ff @(posedge clk) begin
    if (commit) mem[cand_addr] <= cand_data;
  end

  // Read stage: the array is sampled before this edge's write lands
  // (read-before-write). A hit on the pending entry takes the buffered data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      dout   <= '0;
    end else begin
      rvalid <= ren;
      if (!ren)     dout <= '0;
      else if (fwd) dout <= pend_data;
      else          dout <= mem[raddr];
    end
  end

  // Pending-buffer stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
    end else if (accept && conflict) begin
      pend_valid <= 1'b1;
    end else if (pend_valid && !conflict) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && conflict) begin
      pend_addr <= waddr;
      pend_data <= din;
    end
  end

  // Conflict-counter stage
  always_ff @(posedge clk) begin
    if (!rst_n)        conflict_cnt <= '0;
    else if (conflict) conflict_cnt <= sat_inc(conflict_cnt);
  end

endmodule

// File: tb/tb_param_multi_bank_memory.sv
module tb_param_multi_bank_memory;

  logic        clk = 1'b0;
  logic        rst_n;

  // Default-parameter instance
  logic        ren, wen;
  logic [10:0] raddr, waddr;
  logic [7:0]  din, dout;
  logic        rvalid, wready;
  logic [15:0] conflict_cnt;

  // CNT_W=4 instance for saturation
  logic        s_ren, s_wen;
  logic [10:0] s_raddr, s_waddr;
  logic [7:0]  s_din, s_dout;
  logic        s_rvalid, s_wready;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_multi_bank_memory dut (
    .clk(clk), .rst_n(rst_n),
    .ren(ren), .raddr(raddr), .dout(dout), .rvalid(rvalid),
    .wen(wen), .waddr(waddr), .din(din), .wready(wready),
    .conflict_cnt(conflict_cnt)
  );

  param_multi_bank_memory #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .ren(s_ren), .raddr(s_raddr), .dout(s_dout), .rvalid(s_rvalid),
    .wen(s_wen), .waddr(s_waddr), .din(s_din), .wready(s_wready),
    .conflict_cnt(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [10:0] ra,
                       input logic w, input logic [10:0] wa, input logic [7:0] d);
    ren = r; raddr = ra; wen = w; waddr = wa; din = d;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 11'h000, 1'b0, 11'h000, 8'h00);
    s_ren = 1'b0; s_raddr = '0; s_wen = 1'b0; s_waddr = '0; s_din = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_rvalid", rvalid, 0);
    check("reset_dout", dout, 0);
    check("reset_wready", wready, 1);
    check("reset_cnt", conflict_cnt, 0);

    // Basic write then read
    drive(1'b0, 11'h000, 1'b1, 11'h055, 8'hA5); tick();
    drive(1'b1, 11'h055, 1'b0, 11'h000, 8'h00); tick();
    check("basic_rvalid", rvalid, 1);
    check("basic_dout", dout, 8'hA5);
    drive(1'b0, 11'h000, 1'b0, 11'h000, 8'h00); tick();
    check("idle_rvalid", rvalid, 0);
    check("idle_dout", dout, 0);

    // Parallel access in different sub-banks
    drive(1'b1, 11'h600, 1'b1, 11'h000, 8'h11); tick();
    check("par_wready", wready, 1);
    check("par_cnt", conflict_cnt, 0);
    drive(1'b1, 11'h000, 1'b0, 11'h000, 8'h00); tick();
    check("par_dout", dout, 8'h11);

    // Conflict and retire
    drive(1'b0, 11'h000, 1'b1, 11'h001, 8'h00); tick();
    drive(1'b1, 11'h002, 1'b1, 11'h001, 8'h3C); tick();
    check("conf_wready", wready, 0);
    check("conf_cnt", conflict_cnt, 1);
    drive(1'b0, 11'h000, 1'b0, 11'h000, 8'h00); tick();
    check("retire_wready", wready, 1);
    check("retire_cnt", conflict_cnt, 1);
    drive(1'b1, 11'h001, 1'b0, 11'h000, 8'h00); tick();
    check("retire_dout", dout, 8'h3C);

    // Read-before-write on the same address, then forwarding of that write
    drive(1'b1, 11'h001, 1'b1, 11'h001, 8'h5A); tick();
    check("rbw_dout", dout, 8'h3C);
    check("rbw_cnt", conflict_cnt, 2);
    drive(1'b1, 11'h001, 1'b0, 11'h000, 8'h00); tick();
    check("rbw_fwd_dout", dout, 8'h5A);
    check("rbw_fwd_wready", wready, 0);
    check("rbw_fwd_cnt", conflict_cnt, 3);
    drive(1'b0, 11'h000, 1'b0, 11'h000, 8'h00); tick();
    check("rbw_retire_wready", wready, 1);

    // Forwarding while a write is held; wen during pending must be ignored
    drive(1'b0, 11'h000, 1'b1, 11'h400, 8'h22); tick();
    drive(1'b1, 11'h010, 1'b1, 11'h011, 8'h77); tick();
    check("fwd_hold_wready", wready, 0);
    check("fwd_hold_cnt1", conflict_cnt, 4);
    drive(1'b1, 11'h010, 1'b1, 11'h400, 8'hEE); tick();
    check("fwd_hold_cnt2", conflict_cnt, 5);
    drive(1'b1, 11'h011, 1'b1, 11'h400, 8'hEE); tick();
    check("fwd_rvalid", rvalid, 1);
    check("fwd_dout", dout, 8'h77);
    check("fwd_wready", wready, 0);
    check("fwd_cnt", conflict_cnt, 6);
    drive(1'b0, 11'h000, 1'b0, 11'h000, 8'h00); tick();
    check("fwd_retire_wready", wready, 1);
    check("fwd_retire_cnt", conflict_cnt, 6);
    drive(1'b1, 11'h011, 1'b0, 11'h000, 8'h00); tick();
    check("fwd_after_dout", dout, 8'h77);
    drive(1'b1, 11'h400, 1'b0, 11'h000, 8'h00); tick();
    check("ignored_wen_dout", dout, 8'h22);

    // Reset while a write is pending
    drive(1'b0, 11'h000, 1'b1, 11'h001, 8'h3C); tick();
    drive(1'b1, 11'h000, 1'b1, 11'h001, 8'h99); tick();
    check("rst_pend_wready", wready, 0);
    check("rst_pend_cnt", conflict_cnt, 7);
    rst_n = 1'b0;
    drive(1'b1, 11'h055, 1'b0, 11'h000, 8'h00); tick();
    rst_n = 1'b1;
    check("rst_mid_wready", wready, 1);
    check("rst_mid_rvalid", rvalid, 0);
    check("rst_mid_dout", dout, 0);
    check("rst_mid_cnt", conflict_cnt, 0);
    drive(1'b1, 11'h001, 1'b0, 11'h000, 8'h00); tick();
    check("rst_discard_dout", dout, 8'h3C);
    drive(1'b0, 11'h000, 1'b0, 11'h000, 8'h00);

    // Saturation on the CNT_W=4 instance: 20 conflicting cycles
    s_ren = 1'b1; s_raddr = 11'h010; s_wen = 1'b1; s_waddr = 11'h011; s_din = 8'h42;
    tick();
    s_wen = 1'b0;
    check("sat_cnt1", s_cnt, 1);
    for (int i = 0; i < 13; i++) tick();
    check("sat_cnt14", s_cnt, 14);
    tick();
    check("sat_cnt15", s_cnt, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_cnt_hold", s_cnt, 15);
    check("sat_wready", s_wready, 0);
    s_ren = 1'b0; tick();
    check("sat_retire_wready", s_wready, 1);
    check("sat_retire_cnt", s_cnt, 15);
    s_ren = 1'b1; s_raddr = 11'h011; tick();
    check("sat_read_dout", s_dout, 8'h42);
    s_ren = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
